// File: rtl/button_debouncer_pkg.sv
// Shared types and helpers for the push-button debouncer.
//   db_state_t : debounce FSM state encoding (also exported on the debug port)
//   cnt_width  : bits needed to hold values 0..max_val
//   max2       : larger of two integers (used to size the repeat counter)
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } db_state_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Signal bundle between a button source and the debouncer.
//   btn_raw   : raw asynchronous pin (source -> debouncer)
//   btn_level : debounced level
//   btn_rise  : one-cycle strobe on accepted 0->1
//   btn_fall  : one-cycle strobe on accepted 1->0
//   btn_press : rise strobe OR auto-repeat strobe
//   dbg_state : current debounce FSM state, for observation only
// There is no valid/ready handshake here: btn_raw is a level sampled every
// clock, and every output is a registered level or a single-cycle strobe that
// the consumer must take in the cycle it is high (no back-pressure).
interface button_debouncer_if;
  import button_debouncer_pkg::*;

  logic      btn_raw;
  logic      btn_level;
  logic      btn_rise;
  logic      btn_fall;
  logic      btn_press;
  db_state_t dbg_state;

  modport master (
    output btn_raw,
    input  btn_level, btn_rise, btn_fall, btn_press, dbg_state
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_rise, btn_fall, btn_press, dbg_state
  );
endinterface

// File: rtl/button_debouncer_sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
//   clk     : destination clock
//   clear_n : asynchronous active-low reset, clears every stage to 0
//   d_i     : asynchronous input
//   q_o     : d_i delayed through STAGES flops
module button_debouncer_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clear_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw push-button for the single-step clock path.
//   clk     : system clock
//   clear_n : asynchronous active-low reset
//   bus     : slave side of button_debouncer_if (btn_raw in; level, rise,
//             fall, press strobes and FSM debug state out)
// The pin is synchronised, then must hold its new value for DEBOUNCE_CYCLES
// cycles before it is accepted. All outputs are registered.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 25_000_000
) (
  input logic           clk,
  input logic           clear_n,
  button_debouncer_if.slave bus
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int RP_W = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));

  typedef logic [DB_W-1:0] db_cnt_t;
  typedef logic [RP_W-1:0] rp_cnt_t;

  localparam db_cnt_t DB_LOAD  = db_cnt_t'(DEBOUNCE_CYCLES - 1);
  localparam db_cnt_t DB_ONE   = db_cnt_t'(1);
  localparam rp_cnt_t RP_DELAY = rp_cnt_t'(REPEAT_DELAY - 1);
  localparam rp_cnt_t RP_PER   = rp_cnt_t'(REPEAT_PERIOD - 1);
  localparam rp_cnt_t RP_ONE   = rp_cnt_t'(1);

  logic      btn_sync;
  db_state_t state_q, state_d;
  db_cnt_t   db_cnt_q, db_cnt_d;
  rp_cnt_t   rp_cnt_q, rp_cnt_d;
  logic      level_q, level_d;
  logic      rise_q, rise_d;
  logic      fall_q, fall_d;
  logic      press_q, press_d;
  logic      repeat_d;

  button_debouncer_sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .clear_n (clear_n),
    .d_i     (bus.btn_raw),
    .q_o     (btn_sync)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= ST_LOW;
      db_cnt_q <= '0;
      rp_cnt_q <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      rp_cnt_q <= rp_cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      press_q  <= press_d;
    end
  end

  // In every waiting state the bounce check comes before counter expiry.
  // The repeat counter only runs while HIGH with the input still high; the
  // cycle that leaves HIGH and all of WAIT_LOW leave it frozen, so a short
  // release glitch only delays the repeat cadence.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    rp_cnt_d = rp_cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    repeat_d = 1'b0;

    case (state_q)
      ST_LOW: begin
        level_d = 1'b0;
        if (btn_sync) begin
          state_d  = ST_WAIT_HIGH;
          db_cnt_d = DB_LOAD;
        end
      end
      ST_WAIT_HIGH: begin
        if (!btn_sync) begin
          state_d = ST_LOW;
        end else if (db_cnt_q != '0) begin
          db_cnt_d = db_cnt_q - DB_ONE;
        end else begin
          state_d  = ST_HIGH;
          level_d  = 1'b1;
          rise_d   = 1'b1;
          rp_cnt_d = RP_DELAY;
        end
      end
      ST_HIGH: begin
        if (!btn_sync) begin
          state_d  = ST_WAIT_LOW;
          db_cnt_d = DB_LOAD;
        end else if (rp_cnt_q == '0) begin
          repeat_d = 1'b1;
          rp_cnt_d = RP_PER;
        end else begin
          rp_cnt_d = rp_cnt_q - RP_ONE;
        end
      end
      ST_WAIT_LOW: begin
        if (btn_sync) begin
          state_d = ST_HIGH;
        end else if (db_cnt_q != '0) begin
          db_cnt_d = db_cnt_q - DB_ONE;
        end else begin
          state_d = ST_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end
      end
      default: begin
        state_d  = ST_LOW;
        db_cnt_d = '0;
        rp_cnt_d = '0;
        level_d  = 1'b0;
      end
    endcase

    // Without auto-repeat the counter is held at zero so it optimises away.
    if (!REPEAT_EN) begin
      rp_cnt_d = '0;
      repeat_d = 1'b0;
    end

    press_d = rise_d | repeat_d;
  end

  assign bus.btn_level = level_q;
  assign bus.btn_rise  = rise_q;
  assign bus.btn_fall  = fall_q;
  assign bus.btn_press = press_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;
  import button_debouncer_pkg::*;

  localparam int DB  = 4;
  localparam int SS  = 2;
  localparam int RD  = 10;
  localparam int RPD = 3;

  logic clk     = 1'b0;
  logic clear_n = 1'b0;
  logic btn_raw = 1'b0;

  int errors = 0;
  int checks = 0;

  button_debouncer_if if_norep();
  button_debouncer_if if_rep();

  assign if_norep.btn_raw = btn_raw;
  assign if_rep.btn_raw   = btn_raw;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DB),
    .SYNC_STAGES     (SS),
    .REPEAT_EN       (1'b0),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RPD)
  ) u_norep (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (if_norep)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES (DB),
    .SYNC_STAGES     (SS),
    .REPEAT_EN       (1'b1),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RPD)
  ) u_rep (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (if_rep)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_low();
    btn_raw = 1'b0;
    repeat (12) step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [9:0] obs;
    clear_n = 1'b0;
    btn_raw = 1'b1;
    repeat (3) step();
    obs = {if_norep.btn_level, if_norep.btn_rise, if_norep.btn_fall, if_norep.btn_press,
           if_rep.btn_level, if_rep.btn_rise, if_rep.btn_fall, if_rep.btn_press,
           (if_norep.dbg_state != ST_LOW), (if_rep.dbg_state != ST_LOW)};
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", obs, 10'b0);
    end
    clear_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      checks++;
      if ({if_norep.btn_rise, if_rep.btn_rise} !== {2{i == 7}}) begin
        errors++;
        $display("FAIL reset_release_rise edge %0d: got %b want %b", i,
                 {if_norep.btn_rise, if_rep.btn_rise}, {2{i == 7}});
      end
    end
    checks++;
    if ({if_norep.btn_level, if_norep.btn_press} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release_level: got %b want 11",
               {if_norep.btn_level, if_norep.btn_press});
    end
    idle_low();
  endtask

  task automatic test_bounce();
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] obs;
    for (int i = 0; i < 15; i++) begin
      btn_raw = (i < 5) ? pat[i] : 1'b0;
      step();
      obs = {if_norep.btn_level, if_norep.btn_rise, if_norep.btn_fall, if_norep.btn_press,
             if_rep.btn_level, if_rep.btn_rise, if_rep.btn_fall, if_rep.btn_press};
      checks++;
      if (obs !== 8'b0) begin
        errors++;
        $display("FAIL bounce cycle %0d: got %b want 00000000", i, obs);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] obs, exp;
    btn_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      obs = {if_norep.btn_level, if_norep.btn_rise, if_norep.btn_fall, if_norep.btn_press};
      exp = {i >= 7, i == 7, 1'b0, i == 7};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL press_hold cycle %0d: got lvl/rise/fall/press %b want %b", i, obs, exp);
      end
    end
    btn_raw = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      step();
      obs = {if_norep.btn_level, if_norep.btn_rise, if_norep.btn_fall, if_norep.btn_press};
      exp = {j < 7, 1'b0, j == 7, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL press_release cycle %0d: got lvl/rise/fall/press %b want %b", j, obs, exp);
      end
    end
  endtask

  task automatic test_repeat();
    logic exp_p;
    btn_raw = 1'b1;
    repeat (7) step();
    checks++;
    if ({if_rep.btn_rise, if_rep.btn_press} !== 2'b11) begin
      errors++;
      $display("FAIL repeat_rise: got rise/press %b want 11", {if_rep.btn_rise, if_rep.btn_press});
    end
    for (int k = 1; k <= 30; k++) begin
      step();
      exp_p = (k == 10) || (k > 10 && ((k - 10) % 3) == 0);
      checks++;
      if ({if_rep.btn_rise, if_rep.btn_press, if_norep.btn_press} !== {1'b0, exp_p, 1'b0}) begin
        errors++;
        $display("FAIL repeat +%0d: got rise/press/norep_press %b want %b", k,
                 {if_rep.btn_rise, if_rep.btn_press, if_norep.btn_press}, {1'b0, exp_p, 1'b0});
      end
    end
    idle_low();
  endtask

  task automatic test_release_glitch();
    logic exp_p;
    logic [4:0] obs;
    btn_raw = 1'b1;
    repeat (7) step();
    checks++;
    if (if_rep.btn_rise !== 1'b1) begin
      errors++;
      $display("FAIL glitch_rise: got %b want 1", if_rep.btn_rise);
    end
    for (int k = 1; k <= 30; k++) begin
      step();
      // Input low for two sampled cycles freezes the repeat counter for three.
      exp_p = (k >= 13) && (((k - 13) % 3) == 0);
      obs = {if_rep.btn_level, if_rep.btn_fall, if_rep.btn_press,
             if_norep.btn_level, if_norep.btn_fall};
      checks++;
      if (obs !== {1'b1, 1'b0, exp_p, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL glitch +%0d: got %b want %b", k, obs, {1'b1, 1'b0, exp_p, 1'b1, 1'b0});
      end
      if (k == 5) btn_raw = 1'b0;
      if (k == 7) btn_raw = 1'b1;
    end
    idle_low();
  endtask

  task automatic test_reset_mid_debounce();
    logic [8:0] obs;
    btn_raw = 1'b1;
    repeat (4) step();
    checks++;
    if (if_norep.dbg_state !== ST_WAIT_HIGH) begin
      errors++;
      $display("FAIL mid_db_state: got %0d want %0d", if_norep.dbg_state, ST_WAIT_HIGH);
    end
    clear_n = 1'b0;
    #1;
    obs = {if_norep.btn_level, if_norep.btn_rise, if_norep.btn_fall, if_norep.btn_press,
           if_rep.btn_level, if_rep.btn_rise, if_rep.btn_fall, if_rep.btn_press,
           (if_norep.dbg_state != ST_LOW)};
    checks++;
    if (obs !== 9'b0) begin
      errors++;
      $display("FAIL mid_db_reset: got %b want 000000000", obs);
    end
    repeat (2) step();
    clear_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      checks++;
      if ({if_norep.btn_rise, if_norep.btn_level} !== {i == 7, i == 7}) begin
        errors++;
        $display("FAIL mid_db_redebounce edge %0d: got rise/lvl %b want %b", i,
                 {if_norep.btn_rise, if_norep.btn_level}, {i == 7, i == 7});
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    logic [3:0] obs;
    // Button is still held and accepted from the previous test.
    repeat (12) step();
    clear_n = 1'b0;
    btn_raw = 1'b0;
    #1;
    obs = {if_rep.btn_level, if_rep.btn_rise, if_rep.btn_fall, if_rep.btn_press};
    checks++;
    if (obs !== 4'b0) begin
      errors++;
      $display("FAIL mid_rep_reset: got %b want 0000", obs);
    end
    step();
    clear_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      obs = {if_rep.btn_level, if_rep.btn_rise, if_rep.btn_fall, if_rep.btn_press};
      checks++;
      if (obs !== 4'b0) begin
        errors++;
        $display("FAIL mid_rep_release cycle %0d: got %b want 0000", i, obs);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_repeat();
    test_release_glitch();
    test_reset_mid_debounce();
    test_reset_mid_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
